crop_rescale: RTL

CROP_RESCALE -- requirements
Module: crop_rescale

---
 rtl/aug_pkg.sv | 32 +++
 rtl/frame_buffer.sv | 23 ++
 rtl/crop_rescale.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/aug_pkg.sv
// rtl/aug_pkg.sv - shared constants, crop lookup and FSM state type for crop_rescale
package aug_pkg;

   localparam int IMG_W      = 28;
   localparam int IMG_PIXELS = IMG_W * IMG_W;
   localparam int PIX_W      = 8;

   localparam int CROP_0 = 28;
   localparam int CROP_1 = 24;
   localparam int CROP_2 = 20;
   localparam int CROP_3 = 16;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   function automatic int crop_size(input logic [1:0] sel);
      case (sel)
         2'd0:    crop_size = CROP_0;
         2'd1:    crop_size = CROP_1;
         2'd2:    crop_size = CROP_2;
         default: crop_size = CROP_3;
      endcase
   endfunction

   // Centred crop: equal margin on both sides of each axis.
   function automatic int crop_off(input int img_w, input logic [1:0] sel);
      crop_off = (img_w - crop_size(sel)) / 2;
   endfunction

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - single-write, asynchronous-read pixel store (distributed RAM)
module frame_buffer #(
   parameter int DEPTH = 784,
   parameter int PIX_W = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [PIX_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/crop_rescale.sv
// rtl/crop_rescale.sv - buffers one image, then emits a centred crop rescaled by nearest neighbour
module crop_rescale
   import aug_pkg::state_t, aug_pkg::LOAD, aug_pkg::EMIT, aug_pkg::crop_size, aug_pkg::crop_off;
#(
   parameter int IMG_W = aug_pkg::IMG_W,
   parameter int PIX_W = aug_pkg::PIX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       scale,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic             out_last,
   output logic             scale_advance
);

   localparam int PIXELS = IMG_W * IMG_W;
   localparam int AW     = $clog2(PIXELS);
   localparam int CW     = $clog2(IMG_W);
   localparam int ACC_W  = CW + 1;
   localparam logic [AW-1:0]    LAST_ADDR  = AW'(PIXELS - 1);
   localparam logic [CW-1:0]    LAST_COORD = CW'(IMG_W - 1);
   localparam logic [ACC_W-1:0] IMG_W_ACC  = ACC_W'(IMG_W);

   state_t           state_q, state_d;
   logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
   logic [1:0]       scale_q, scale_d;
   logic [CW-1:0]    out_col_q, out_col_d, out_row_q, out_row_d;
   logic [CW-1:0]    src_col_q, src_col_d, src_row_q, src_row_d;
   logic [ACC_W-1:0] col_acc_q, col_acc_d, row_acc_q, row_acc_d;

   logic             in_xfer, out_xfer, wr_last;
   logic [ACC_W-1:0] crop_c, col_sum, row_sum;
   logic [CW-1:0]    off_q, off_in;
   logic [AW-1:0]    raddr;

   assign in_xfer  = in_valid && (state_q == LOAD);
   assign out_xfer = out_ready && (state_q == EMIT);
   assign wr_last  = (wr_cnt_q == LAST_ADDR);
   assign crop_c   = ACC_W'(crop_size(scale_q));
   assign off_q    = CW'(crop_off(IMG_W, scale_q));
   assign off_in   = CW'(crop_off(IMG_W, scale));
   assign col_sum  = col_acc_q + crop_c;
   assign row_sum  = row_acc_q + crop_c;

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      scale_d   = scale_q;
      out_col_d = out_col_q;
      out_row_d = out_row_q;
      src_col_d = src_col_q;
      src_row_d = src_row_q;
      col_acc_d = col_acc_q;
      row_acc_d = row_acc_q;
      case (state_q)
         LOAD: begin
            if (in_xfer) begin
               if (wr_last) begin
                  wr_cnt_d  = '0;
                  scale_d   = scale;
                  src_col_d = off_in;
                  src_row_d = off_in;
                  state_d   = EMIT;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            if (out_xfer) begin
               if (out_col_q == LAST_COORD) begin
                  out_col_d = '0;
                  col_acc_d = '0;
                  src_col_d = off_q;
                  if (out_row_q == LAST_COORD) begin
                     state_d   = LOAD;
                     out_row_d = '0;
                     row_acc_d = '0;
                     src_row_d = '0;
                     src_col_d = '0;
                  end else begin
                     out_row_d = out_row_q + 1'b1;
                     if (row_sum >= IMG_W_ACC) begin
                        row_acc_d = row_sum - IMG_W_ACC;
                        src_row_d = src_row_q + 1'b1;
                     end else begin
                        row_acc_d = row_sum;
                     end
                  end
               end else begin
                  out_col_d = out_col_q + 1'b1;
                  if (col_sum >= IMG_W_ACC) begin
                     col_acc_d = col_sum - IMG_W_ACC;
                     src_col_d = src_col_q + 1'b1;
                  end else begin
                     col_acc_d = col_sum;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= LOAD;
         wr_cnt_q  <= '0;
         scale_q   <= '0;
         out_col_q <= '0;
         out_row_q <= '0;
         src_col_q <= '0;
         src_row_q <= '0;
         col_acc_q <= '0;
         row_acc_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         scale_q   <= scale_d;
         out_col_q <= out_col_d;
         out_row_q <= out_row_d;
         src_col_q <= src_col_d;
         src_row_q <= src_row_d;
         col_acc_q <= col_acc_d;
         row_acc_q <= row_acc_d;
      end
   end

   assign raddr = AW'(int'(src_row_q) * IMG_W + int'(src_col_q));

   frame_buffer #(
      .DEPTH (PIXELS),
      .PIX_W (PIX_W)
   ) u_frame_buffer (
      .clk   (clk),
      .we    (in_xfer),
      .waddr (wr_cnt_q),
      .wdata (in_data),
      .raddr (raddr),
      .rdata (out_data)
   );

   assign in_ready      = (state_q == LOAD);
   assign out_valid     = (state_q == EMIT);
   assign out_last      = (state_q == EMIT) && (out_row_q == LAST_COORD) && (out_col_q == LAST_COORD);
   assign scale_advance = in_xfer && wr_last;

endmodule
